// File: rtl/bus_decoder_ws_if.sv
// Bus bundle between the 65C02 side and the address decoder / wait-state generator.
// The master side drives address, strobes and device ready; the slave side is the decoder.
interface bus_decoder_ws_if #(
  parameter int ADDR_W = 16,
  parameter int NREG   = 4
);
  logic [ADDR_W-1:0] address;
  logic              write_enable;
  logic              ext_rdy;
  logic              fault_clr;
  logic [NREG-1:0]   sel;
  logic              we_out;
  logic              rdy;
  logic [2:0]        region_idx;
  logic              unmapped;
  logic              wr_fault;

  modport master (
    output address, write_enable, ext_rdy, fault_clr,
    input  sel, we_out, rdy, region_idx, unmapped, wr_fault
  );

  modport slave (
    input  address, write_enable, ext_rdy, fault_clr,
    output sel, we_out, rdy, region_idx, unmapped, wr_fault
  );
endinterface

// File: rtl/bus_decoder_ws.sv
// Address decoder and wait-state generator for the 65C02 bus: one-hot chip selects,
// read-only write gating, and RDY stretching by per-region wait states plus ext_rdy.
module bus_decoder_ws #(
  parameter int                     ADDR_W   = 16,
  parameter int                     NREG     = 4,
  parameter logic [NREG*ADDR_W-1:0] REG_BASE = {16'h9000, 16'hE000, 16'h8000, 16'h0000},
  parameter logic [NREG*ADDR_W-1:0] REG_MASK = {16'hF000, 16'hE000, 16'hF000, 16'h8000},
  parameter logic [NREG*4-1:0]      REG_WS   = {4'd3, 4'd1, 4'd2, 4'd0},
  parameter logic [NREG-1:0]        REG_RO   = 4'b0100
) (
  input logic             CLOCK_IN,
  input logic             RESET,
  bus_decoder_ws_if.slave bus
);

  typedef enum logic {FIRST, WAIT} state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [3:0]      r_cnt;
  logic [3:0]      w_cnt_next;
  logic [2:0]      r_cur_idx;
  logic            r_cur_hit;
  logic            r_unmapped;
  logic            r_wr_fault;

  logic [NREG-1:0] w_hit;
  logic [3:0]      w_ws_tab [8];
  logic [7:0]      w_ro_tab;
  logic            w_any_hit;
  logic [2:0]      w_hit_idx;
  logic            w_act_hit;
  logic [2:0]      w_act_idx;
  logic [3:0]      w_ws;
  logic            w_ro;
  logic            w_rdy;

  for (genvar gi = 0; gi < 8; gi++) begin : g_tab
    if (gi < NREG) begin : g_used
      assign w_hit[gi]    = (bus.address & REG_MASK[gi*ADDR_W +: ADDR_W]) ==
                            (REG_BASE[gi*ADDR_W +: ADDR_W] & REG_MASK[gi*ADDR_W +: ADDR_W]);
      assign w_ws_tab[gi] = REG_WS[gi*4 +: 4];
      assign w_ro_tab[gi] = REG_RO[gi];
    end else begin : g_unused
      assign w_ws_tab[gi] = 4'd0;
      assign w_ro_tab[gi] = 1'b0;
    end
  end

  // Scan from the top so the lowest-numbered hit is the last one written.
  always_comb begin
    w_any_hit = 1'b0;
    w_hit_idx = 3'd0;
    for (int i = NREG - 1; i >= 0; i--) begin
      if (w_hit[i]) begin
        w_any_hit = 1'b1;
        w_hit_idx = 3'(i);
      end
    end
  end

  // While stalled, the latched region drives the selects so address glitches cannot.
  assign w_act_hit = (r_state == WAIT) ? r_cur_hit : w_any_hit;
  assign w_act_idx = (r_state == WAIT) ? r_cur_idx : w_hit_idx;
  assign w_ws      = w_act_hit ? w_ws_tab[w_act_idx] : 4'd0;
  assign w_ro      = w_act_hit & w_ro_tab[w_act_idx];

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_rdy        = 1'b0;
    case (r_state)
      FIRST: begin
        w_rdy = (w_ws == 4'd0) & bus.ext_rdy;
        if (w_ws != 4'd0) begin
          w_state_next = WAIT;
          w_cnt_next   = w_ws;
        end else if (!bus.ext_rdy) begin
          w_state_next = WAIT;
          w_cnt_next   = 4'd0;
        end
      end
      WAIT: begin
        w_rdy = (r_cnt <= 4'd1) & bus.ext_rdy;
        if (w_rdy) begin
          w_state_next = FIRST;
          w_cnt_next   = 4'd0;
        end else if (r_cnt != 4'd0) begin
          w_cnt_next = r_cnt - 4'd1;
        end
      end
      default: begin
        w_state_next = FIRST;
        w_cnt_next   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge CLOCK_IN or negedge RESET) begin
    if (!RESET) begin
      r_state    <= FIRST;
      r_cnt      <= 4'd0;
      r_cur_idx  <= 3'd0;
      r_cur_hit  <= 1'b0;
      r_unmapped <= 1'b0;
      r_wr_fault <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_cnt      <= w_cnt_next;
      if (r_state == FIRST) begin
        r_cur_idx <= w_hit_idx;
        r_cur_hit <= w_any_hit;
      end
      r_unmapped <= w_rdy & ~w_act_hit;
      // A fault raised on this edge takes priority over a clear request.
      if (w_rdy & bus.write_enable & w_ro)
        r_wr_fault <= 1'b1;
      else if (bus.fault_clr)
        r_wr_fault <= 1'b0;
    end
  end

  assign bus.sel        = w_act_hit ? (NREG'(1) << w_act_idx) : '0;
  assign bus.region_idx = w_act_hit ? w_act_idx : 3'd0;
  assign bus.we_out     = bus.write_enable & ~w_ro & w_act_hit;
  assign bus.rdy        = w_rdy;
  assign bus.unmapped   = r_unmapped;
  assign bus.wr_fault   = r_wr_fault;

endmodule
